// File: rtl/rtob_sched_pkg.sv
// Shared types for the RTOB write scheduler: FSM state codes and 128-bit word layout.
package rtob_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_FLUSH = 3'd3,
      ST_ERROR = 3'd4
   } state_e;

   localparam int WORD_W  = 128;
   localparam int TS_MSB  = 127;
   localparam int TS_LSB  = 64;
   localparam int TS_W    = TS_MSB - TS_LSB + 1;
   localparam int PAY_MSB = 7;
   localparam int PAY_LSB = 0;

   function automatic logic [TS_W-1:0] word_ts(input logic [WORD_W-1:0] w);
      return w[TS_MSB:TS_LSB];
   endfunction

endpackage

// File: rtl/rtob_sched_ctrl_if.sv
// Requester-side bus of the RTOB scheduler: per-requester word valid/data and consume strobe.
interface rtob_sched_ctrl_if #(parameter int N_REQ = 4);
   import rtob_sched_pkg::*;

   logic [N_REQ-1:0]             req_valid;
   logic [N_REQ-1:0][WORD_W-1:0] req_data;
   logic [N_REQ-1:0]             req_ready;

   modport master (output req_valid, output req_data, input req_ready);
   modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/rtob_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the index after the last accepted grant.
module rtob_rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req_i,
   input  logic         accept_i,
   output logic [N-1:0] grant_o
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d, sel;
   int            idx, nxt;

   // Walk the ring backwards so the candidate closest to ptr_q is written last and wins.
   always_comb begin
      grant_o = '0;
      ptr_d   = ptr_q;
      idx     = 0;
      nxt     = 0;
      sel     = '0;
      for (int k = N-1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= N) idx = idx - N;
         sel = PW'(idx);
         if (req_i[sel]) begin
            grant_o      = '0;
            grant_o[sel] = 1'b1;
            nxt          = (idx == N-1) ? 0 : idx + 1;
         end
      end
      if (accept_i && (|grant_o)) ptr_d = PW'(nxt);
   end

   always_ff @(posedge clk) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/rtob_sched_ctrl.sv
// RTOB scheduler: arbitrates requester words into the core FIFO and sequences playback/flush/error.
// Optional RTOB_SCHED_TS_CHECK_EN drops per-requester out-of-order timestamps.
module rtob_sched_ctrl
   import rtob_sched_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                clk,
   input  logic                reset,
   rtob_sched_ctrl_if.slave    req_if,
   input  logic                cmd_start,
   input  logic                cmd_stop,
   input  logic                cmd_flush,
   input  logic                err_clear,
   input  logic                rtob_full,
   input  logic                rtob_empty,
   input  logic                rtob_timestamp_error,
   input  logic                rtob_overflow_error,
   output logic                rtob_write,
   output logic [WORD_W-1:0]   rtob_fifo_din,
   output logic                rtob_auto_start,
   output logic                rtob_flush,
   output logic [2:0]          state,
   output logic [1:0]          err_sticky,
   output logic [31:0]         wr_count,
   output logic [N_REQ-1:0]    drop_sticky
);
   localparam int CW = $clog2(FLUSH_CYCLES + 1);

   state_e            state_q;
   logic              write_q, auto_q, flush_q;
   logic [WORD_W-1:0] din_q;
   logic [CW-1:0]     fcnt_q;
   logic [1:0]        sticky_q;
   logic [31:0]       cnt_q;

   logic              wr_en, write_d, core_err;
   logic [N_REQ-1:0]  grant, pass;
   logic [WORD_W-1:0] word_sel;

   // Intake open in IDLE (preload) and RUN; full is trusted to leave one word of slack.
   assign wr_en    = !reset && !rtob_full && (state_q == ST_IDLE || state_q == ST_RUN);
   assign core_err = rtob_timestamp_error | rtob_overflow_error;

   rtob_rr_arbiter #(.N(N_REQ)) u_arb (
      .clk      (clk),
      .reset    (reset),
      .req_i    (req_if.req_valid & {N_REQ{wr_en}}),
      .accept_i (wr_en),
      .grant_o  (grant)
   );

   assign req_if.req_ready = grant;

   always_comb begin
      word_sel = '0;
      for (int i = 0; i < N_REQ; i++)
         if (grant[i]) word_sel = req_if.req_data[i];
   end

`ifdef RTOB_SCHED_TS_CHECK_EN
   for (genvar i = 0; i < N_REQ; i++) begin : g_ts
      logic [TS_W-1:0] ts, last_q;
      logic            drop_q;
      assign ts             = word_ts(req_if.req_data[i]);
      assign pass[i]        = (ts == '0) || (ts > last_q);
      assign drop_sticky[i] = drop_q;
      always_ff @(posedge clk) begin
         if (reset || state_q == ST_FLUSH) last_q <= '0;
         else if (grant[i] && pass[i])     last_q <= ts;
         if (reset)                        drop_q <= 1'b0;
         else if (grant[i] && !pass[i])    drop_q <= 1'b1;
      end
   end
`else
   assign pass        = '1;
   assign drop_sticky = '0;
`endif

   assign write_d = |(grant & pass);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         write_q  <= 1'b0;
         din_q    <= '0;
         auto_q   <= 1'b0;
         flush_q  <= 1'b0;
         fcnt_q   <= '0;
         sticky_q <= '0;
         cnt_q    <= '0;
      end else begin
         write_q <= write_d;
         if (write_d) begin
            din_q <= word_sel;
            cnt_q <= cnt_q + 32'd1;
         end
         case (state_q)
            ST_IDLE: begin
               if (cmd_flush) begin
                  state_q <= ST_FLUSH;
                  flush_q <= 1'b1;
                  fcnt_q  <= '0;
               end else if (cmd_start) begin
                  state_q <= ST_RUN;
                  auto_q  <= 1'b1;
               end
            end
            ST_RUN, ST_DRAIN: begin
               if (cmd_flush) begin
                  state_q <= ST_FLUSH;
                  flush_q <= 1'b1;
                  fcnt_q  <= '0;
                  auto_q  <= 1'b0;
               end else if (core_err) begin
                  state_q  <= ST_ERROR;
                  auto_q   <= 1'b0;
                  sticky_q <= sticky_q | {rtob_overflow_error, rtob_timestamp_error};
               end else if (state_q == ST_RUN && cmd_stop) begin
                  state_q <= ST_DRAIN;
               end else if (state_q == ST_DRAIN && rtob_empty) begin
                  state_q <= ST_IDLE;
                  auto_q  <= 1'b0;
               end
            end
            ST_FLUSH: begin
               if (fcnt_q == CW'(FLUSH_CYCLES - 1)) begin
                  state_q <= ST_IDLE;
                  flush_q <= 1'b0;
                  fcnt_q  <= '0;
               end else begin
                  fcnt_q <= fcnt_q + CW'(1);
               end
            end
            ST_ERROR: begin
               if (cmd_flush || err_clear) begin
                  state_q <= ST_FLUSH;
                  flush_q <= 1'b1;
                  fcnt_q  <= '0;
                  if (err_clear) sticky_q <= '0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign state           = state_q;
   assign rtob_write      = write_q;
   assign rtob_fifo_din   = din_q;
   assign rtob_auto_start = auto_q;
   assign rtob_flush      = flush_q;
   assign err_sticky      = sticky_q;
   assign wr_count        = cnt_q;

endmodule

// File: tb/tb_rtob_sched_ctrl.sv
// Randomized + directed bench for rtob_sched_ctrl against a queue-based behavioural model.
module tb_rtob_sched_ctrl;
   localparam int N  = 4;
   localparam int FC = 2;

   logic clk = 1'b0;
   logic reset, cmd_start, cmd_stop, cmd_flush, err_clear;
   logic rtob_full, rtob_empty, rtob_timestamp_error, rtob_overflow_error;
   logic rtob_write, rtob_auto_start, rtob_flush;
   logic [127:0] rtob_fifo_din;
   logic [2:0]   state;
   logic [1:0]   err_sticky;
   logic [31:0]  wr_count;
   logic [N-1:0] drop_sticky;

   always #5 clk = ~clk;

   rtob_sched_ctrl_if #(.N_REQ(N)) rif ();

   rtob_sched_ctrl #(.N_REQ(N), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .reset(reset), .req_if(rif),
      .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_flush(cmd_flush), .err_clear(err_clear),
      .rtob_full(rtob_full), .rtob_empty(rtob_empty),
      .rtob_timestamp_error(rtob_timestamp_error), .rtob_overflow_error(rtob_overflow_error),
      .rtob_write(rtob_write), .rtob_fifo_din(rtob_fifo_din), .rtob_auto_start(rtob_auto_start),
      .rtob_flush(rtob_flush), .state(state), .err_sticky(err_sticky), .wr_count(wr_count),
      .drop_sticky(drop_sticky)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
      end
   endtask

   // requester sources and model state
   logic [127:0] q[N][$];
   logic [127:0] dlog[$];
   int           m_state, m_ptr, m_fcnt;
   bit           m_write, m_auto, m_flush;
   logic [127:0] m_din;
   logic [1:0]   m_sticky;
   logic [31:0]  m_cnt;
   logic [N-1:0] m_drop;
   logic [63:0]  m_last[N];
   logic [63:0]  ts_ctr = 64'd0;

   function automatic logic [127:0] mk(input logic [63:0] ts, input logic [7:0] pay);
      logic [55:0] mid;
      mid = {24'($urandom), $urandom};
      return {ts, mid, pay};
   endfunction

   function automatic logic [63:0] next_ts();
      ts_ctr = ts_ctr + 64'd1;
      return ts_ctr;
   endfunction

   task automatic model_reset();
      m_state = 0; m_ptr = 0; m_fcnt = 0;
      m_write = 0; m_auto = 0; m_flush = 0;
      m_din = '0; m_sticky = '0; m_cnt = '0; m_drop = '0;
      for (int i = 0; i < N; i++) m_last[i] = '0;
   endtask

   task automatic tick();
      int g, j, os;
      bit wr;
      logic [N-1:0] exp_rdy;
      logic [127:0] w;
      for (int i = 0; i < N; i++) begin
         rif.req_valid[i] = (q[i].size() > 0);
         rif.req_data[i]  = (q[i].size() > 0) ? q[i][0] : '0;
      end
      #1;
      g = -1;
      if (!reset && !rtob_full && (m_state == 0 || m_state == 1))
         for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (g < 0 && q[j].size() > 0) g = j;
         end
      exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
      chk("req_ready", rif.req_ready, exp_rdy);
      if (reset) model_reset();
      else begin
         os = m_state;
         wr = 0;
         w  = '0;
         if (g >= 0) begin
            w = q[g].pop_front();
            m_ptr = (g + 1) % N;
            wr = 1;
`ifdef RTOB_SCHED_TS_CHECK_EN
            if (w[127:64] != 0 && w[127:64] <= m_last[g]) begin
               wr = 0;
               m_drop[g] = 1'b1;
            end else m_last[g] = w[127:64];
`endif
         end
         m_write = wr;
         if (wr) begin m_din = w; m_cnt = m_cnt + 1; end
         case (m_state)
            0: if (cmd_flush) begin m_state = 3; m_fcnt = 0; end
               else if (cmd_start) m_state = 1;
            1, 2: if (cmd_flush) begin m_state = 3; m_fcnt = 0; end
               else if (rtob_timestamp_error || rtob_overflow_error) begin
                  m_state = 4;
                  m_sticky = m_sticky | {rtob_overflow_error, rtob_timestamp_error};
               end else if (m_state == 1 && cmd_stop) m_state = 2;
               else if (m_state == 2 && rtob_empty) m_state = 0;
            3: begin m_fcnt++; if (m_fcnt >= FC) m_state = 0; end
            4: if (cmd_flush || err_clear) begin
                  if (err_clear) m_sticky = '0;
                  m_state = 3; m_fcnt = 0;
               end
            default: m_state = 0;
         endcase
         m_auto  = (m_state == 1 || m_state == 2);
         m_flush = (m_state == 3);
         if (os == 3) for (int i = 0; i < N; i++) m_last[i] = '0;
      end
      @(posedge clk); #1;
      if (rtob_write) dlog.push_back(rtob_fifo_din);
      chk("state", state, m_state);
      chk("write", rtob_write, m_write);
      if (m_write) chk("din", rtob_fifo_din, m_din);
      chk("auto_start", rtob_auto_start, m_auto);
      chk("flush", rtob_flush, m_flush);
      chk("err_sticky", err_sticky, m_sticky);
      chk("wr_count", wr_count, m_cnt);
      chk("drop_sticky", drop_sticky, m_drop);
      cmd_start = 0; cmd_stop = 0; cmd_flush = 0; err_clear = 0;
      rtob_timestamp_error = 0; rtob_overflow_error = 0;
   endtask

   task automatic do_reset();
      reset = 1; tick(); tick(); reset = 0;
   endtask

   initial begin
      logic [7:0] exp1 [6];
      exp1 = '{8'h00, 8'h10, 8'h01, 8'h11, 8'h02, 8'h12};
      reset = 0; cmd_start = 0; cmd_stop = 0; cmd_flush = 0; err_clear = 0;
      rtob_full = 0; rtob_empty = 0; rtob_timestamp_error = 0; rtob_overflow_error = 0;
      for (int i = 0; i < N; i++) begin
         rif.req_valid[i] = 0;
         rif.req_data[i]  = '0;
      end
      model_reset();
      do_reset();
      chk("rst_state", state, 3'd0);
      chk("rst_cnt", wr_count, 32'd0);
      chk("rst_din", rtob_fifo_din, 128'd0);

      // preload in IDLE then start: strict alternation 0,1
      dlog.delete();
      for (int k = 0; k < 3; k++) begin
         q[0].push_back(mk(next_ts(), 8'(k)));
         q[1].push_back(mk(next_ts(), 8'(16 + k)));
      end
      cmd_start = 1;
      repeat (8) tick();
      chk("pre_n", dlog.size(), 6);
      for (int i = 0; i < 6 && i < dlog.size(); i++) chk("pre_order", dlog[i][7:0], exp1[i]);
      chk("pre_cnt", wr_count, 32'd6);
      chk("pre_state", state, 3'd1);

      // backpressure: nothing moves while full, then RR resumes at req2
      for (int r = 0; r < N; r++)
         for (int k = 0; k < 3; k++) q[r].push_back(mk(next_ts(), 8'(r * 16 + k)));
      rtob_full = 1;
      repeat (5) begin
         tick();
         chk("bp_ready", rif.req_ready, '0);
         chk("bp_write", rtob_write, 1'b0);
      end
      rtob_full = 0;
      dlog.delete();
      repeat (14) tick();
      chk("bp_n", dlog.size(), 12);
      for (int i = 0; i < 12 && i < dlog.size(); i++) chk("bp_rr", dlog[i][7:4], (2 + i) % 4);

      // core timestamp error -> ERROR, clear -> 2-cycle flush -> IDLE
      rtob_timestamp_error = 1;
      tick();
      chk("err_state", state, 3'd4);
      chk("err_sticky", err_sticky, 2'b01);
      chk("err_auto", rtob_auto_start, 1'b0);
      tick();
      err_clear = 1;
      tick();
      chk("clr_flush1", rtob_flush, 1'b1);
      tick();
      chk("clr_flush2", rtob_flush, 1'b1);
      tick();
      chk("clr_idle", state, 3'd0);
      chk("clr_flush0", rtob_flush, 1'b0);
      chk("clr_sticky", err_sticky, 2'b00);

      // drain: hold requester words until core empties
      cmd_start = 1; tick();
      rtob_empty = 0; cmd_stop = 1; tick();
      q[3].push_back(mk(next_ts(), 8'h30));
      q[3].push_back(mk(next_ts(), 8'h31));
      repeat (10) begin
         tick();
         chk("drn_state", state, 3'd2);
         chk("drn_auto", rtob_auto_start, 1'b1);
         chk("drn_ready", rif.req_ready, '0);
      end
      rtob_empty = 1; tick();
      chk("drn_idle", state, 3'd0);
      repeat (3) tick();

      // priority: flush beats error and stop
      cmd_start = 1; tick();
      cmd_flush = 1; cmd_stop = 1; rtob_overflow_error = 1; tick();
      chk("pri_state", state, 3'd3);
      chk("pri_sticky", err_sticky, 2'b00);
      tick(); tick();
      chk("pri_idle", state, 3'd0);

      // timestamp ordering on req2
      do_reset();
      dlog.delete();
      q[2].push_back(mk(64'd10, 8'h20));
      q[2].push_back(mk(64'd20, 8'h21));
      q[2].push_back(mk(64'd15, 8'h22));
      repeat (5) tick();
`ifdef RTOB_SCHED_TS_CHECK_EN
      chk("ts_n", dlog.size(), 2);
      if (dlog.size() >= 2) begin
         chk("ts_w0", dlog[0][127:64], 64'd10);
         chk("ts_w1", dlog[1][127:64], 64'd20);
      end
      chk("ts_drop", drop_sticky, 4'b0100);
`else
      chk("ts_n", dlog.size(), 3);
      chk("ts_drop", drop_sticky, 4'b0000);
`endif

      // reset with a word in flight drops it
      q[0].push_back(mk(next_ts(), 8'h05));
      tick();
      chk("rmw_write", rtob_write, 1'b1);
      reset = 1; tick(); reset = 0;
      chk("rmw_drop", rtob_write, 1'b0);
      chk("rmw_cnt", wr_count, 32'd0);

      // random soak
      for (int c = 0; c < 3000; c++) begin
         if ($urandom % 3 == 0) begin
            int r;
            logic [63:0] ts;
            r  = $urandom_range(0, N - 1);
            ts = ($urandom % 4 == 0) ? 64'($urandom_range(0, 30)) : next_ts();
            if (q[r].size() < 4) q[r].push_back(mk(ts, 8'(r * 16 + c % 16)));
         end
         cmd_start = ($urandom % 8 == 0);
         cmd_stop  = ($urandom % 16 == 0);
         cmd_flush = ($urandom % 40 == 0);
         err_clear = ($urandom % 6 == 0);
         rtob_full = ($urandom % 4 == 0);
         rtob_empty = ($urandom % 4 == 0);
         rtob_timestamp_error = ($urandom % 50 == 0);
         rtob_overflow_error  = ($urandom % 50 == 0);
         reset = ($urandom % 300 == 0);
         tick();
         reset = 0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rtob_sched_ctrl.md
RTOB_SCHED_CTRL -- requirements
Module: rtob_sched_ctrl

Interface
REQ-001 SHALL have parameter N_REQ, 4, number of write requesters (2..8).
REQ-002 SHALL have parameter FLUSH_CYCLES, 2, cycles rtob_flush is held in FLUSH.
REQ-003 SHALL have one clock `clk`, and `reset` synchronous active-high; both ports come first.
REQ-004 SHALL have ports:
  clk  in  1  clock
  reset  in  1  sync active-high reset
  req_valid  in  N_REQ  requester word valid
  req_data  in  N_REQ*128  requester words; [127:64] timestamp, [7:0] payload
  req_ready  out  N_REQ  word consumed this cycle
  cmd_start  in  1  pulse: begin playback
  cmd_stop  in  1  pulse: stop intake, drain
  cmd_flush  in  1  pulse: discard buffer
  err_clear  in  1  pulse: leave ERROR
  rtob_full  in  1  core full
  rtob_empty  in  1  core empty
  rtob_timestamp_error  in  1  core late-event error
  rtob_overflow_error  in  1  core overflow error
  rtob_write  out  1  core write strobe
  rtob_fifo_din  out  128  core write word
  rtob_auto_start  out  1  core playback enable
  rtob_flush  out  1  core flush
  state  out  3  FSM state code
  err_sticky  out  2  {overflow, timestamp} latched errors
  wr_count  out  32  words written to core, wraps
  drop_sticky  out  N_REQ  per-requester out-of-order drops

Function
REQ-005 SHALL implement FSM IDLE=0, RUN=1, DRAIN=2, FLUSH=3, ERROR=4; encoding appears on `state`.
REQ-006 SHALL apply transition priority: cmd_flush > core error > cmd_stop > cmd_start.
REQ-007 SHALL transition from any state except FLUSH on cmd_flush to FLUSH; FLUSH SHALL assert rtob_flush for exactly FLUSH_CYCLES cycles, then go to IDLE.
REQ-008 SHALL transition IDLE->RUN on cmd_start; RUN->DRAIN on cmd_stop; DRAIN->IDLE on the first cycle rtob_empty=1.
REQ-009 SHALL transition RUN or DRAIN->ERROR when rtob_timestamp_error or rtob_overflow_error is 1, and SHALL set the matching err_sticky bit in the same cycle.
REQ-010 SHALL transition ERROR->FLUSH on err_clear; err_sticky SHALL clear only on err_clear or reset.
REQ-011 SHALL drive rtob_auto_start=1 exactly in RUN and DRAIN, registered.
REQ-012 SHALL accept writes only in IDLE (preload) and RUN, and only when rtob_full=0.
REQ-013 SHALL grant at most one requester per cycle, round-robin, starting from the index after the last grant; after reset the start index is 0.
REQ-014 SHALL assert req_ready for the granted requester combinationally in its grant cycle.
REQ-015 SHALL register the granted word: rtob_write and rtob_fifo_din SHALL appear exactly 1 cycle after the grant; rtob_write SHALL be 0 otherwise.
REQ-016 SHALL rely on the core's full threshold for the 1-cycle full-flag slack; at most one write issues after full rises.
REQ-017 SHALL increment wr_count once per rtob_write, modulo 2^32.
REQ-018 SHALL hold req_ready=0 in DRAIN, FLUSH and ERROR; requester words SHALL be held, not consumed.
REQ-019 SHALL ignore cmd_start outside IDLE, cmd_stop outside RUN, and err_clear outside ERROR.

Reset
REQ-020 SHALL set on reset: state=IDLE, rtob_write=0, rtob_fifo_din=0, rtob_auto_start=0, rtob_flush=0, err_sticky=0, wr_count=0, drop_sticky=0, RR pointer=0, flush counter=0.
REQ-021 SHALL, on reset mid-write, drop the in-flight registered word (rtob_write=0 on the next cycle).

Configuration
REQ-022 SHALL, with RTOB_SCHED_TS_CHECK_EN defined, keep a per-requester last-accepted timestamp (cleared by reset and FLUSH); a granted word whose timestamp is <= that value SHALL be consumed (req_ready=1), not written, and SHALL set drop_sticky[i]; a timestamp of 0 SHALL always pass and reset the reference.
REQ-023 SHALL, without RTOB_SCHED_TS_CHECK_EN, forward every granted word and tie drop_sticky to 0.

Structure
REQ-024 SHALL place the state enum, state codes, and the 128-bit word field offsets in package rtob_sched_pkg.
REQ-025 SHALL implement arbitration in sub-module rtob_rr_arbiter (N_REQ-wide request in, one-hot grant out, advance on accept).

Verification
REQ-026 Preload: IDLE, req0 and req1 valid 3 words each, then cmd_start -> writes alternate 0,1,0,1,0,1 (one per cycle, 1-cycle latency), wr_count=6, state=1.
REQ-027 Backpressure: rtob_full=1 for 5 cycles with all requesters valid -> req_ready=0 and rtob_write=0 during those 5 cycles; RR order resumes afterwards.
REQ-028 Error: in RUN pulse rtob_timestamp_error -> state=4, err_sticky=2'b01, auto_start=0; err_clear -> rtob_flush high 2 cycles, then IDLE, err_sticky=0.
REQ-029 Drain: cmd_stop with rtob_empty=0 for 10 cycles -> state=2, auto_start=1, req_ready=0; rtob_empty=1 -> IDLE next cycle.
REQ-030 Priority: cmd_flush, cmd_stop and rtob_overflow_error in the same RUN cycle -> FLUSH.
REQ-031 TS check (macro on): req2 timestamps 10, 20, 15 -> 10 and 20 written; 15 consumed, not written, drop_sticky[2]=1.
